gated_freq_meter: RTL and testbench

GATED_FREQ_METER -- requirements
Module: gated_freq_meter

---
 rtl/gated_freq_meter.sv | 118 +++++++++++
 tb/tb_gated_freq_meter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gated_freq_meter.sv
// Gated frequency meter: counts synchronised rising edges of sig_in over a fixed
// clk_in window in BCD and hands each window's result to a valid/ready consumer.
module gated_freq_meter #(
  parameter int unsigned DIGITS_NUM  = 6,
  parameter int unsigned GATE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk_in,
  input  logic                    resetn_in,
  input  logic                    sig_in,
  input  logic                    enable_in,
  output logic [4*DIGITS_NUM-1:0] digits_out,
  output logic                    overflow_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    overrun_out
);

  localparam int unsigned DW = 4 * DIGITS_NUM;
  localparam int unsigned GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  logic [GW-1:0]          r_gate;
  logic [DW-1:0]          r_bcd;
  logic                   r_ovf;

  logic          w_edge;
  logic          w_cnt_pulse;
  logic          w_gate_end;
  logic          w_handshake;
  logic          w_all9;
  logic [DW-1:0] w_bcd_inc;
  logic [DW-1:0] w_bcd_next;
  logic          w_ovf_next;

  // Synchroniser chain plus one delayed copy of its last stage for edge detection
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge      = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
  assign w_cnt_pulse = w_edge & enable_in;
  assign w_gate_end  = enable_in & (r_gate == GATE_LAST);
  assign w_handshake = valid_out & ready_in;

  // Gate timer: wraps straight back to zero at window end, held at zero while disabled
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_gate <= '0;
    end else if (!enable_in || w_gate_end) begin
      r_gate <= '0;
    end else begin
      r_gate <= r_gate + GW'(1);
    end
  end

  // Ripple-carry BCD increment; carry survives to the end only when every digit is 9
  always_comb begin : bcd_inc
    logic carry;
    carry     = 1'b1;
    w_bcd_inc = r_bcd;
    for (int i = 0; i < int'(DIGITS_NUM); i++) begin
      if (carry) begin
        if (r_bcd[4*i +: 4] == 4'd9) begin
          w_bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          w_bcd_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    w_all9 = carry;
  end

  // Saturate at all 9s instead of wrapping, and remember that it happened
  assign w_bcd_next = (w_cnt_pulse && !w_all9) ? w_bcd_inc : r_bcd;
  assign w_ovf_next = r_ovf | (w_cnt_pulse & w_all9);

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_bcd <= '0;
      r_ovf <= 1'b0;
    end else if (!enable_in || w_gate_end) begin
      r_bcd <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_bcd <= w_bcd_next;
      r_ovf <= w_ovf_next;
    end
  end

  // Result latch and handshake; a new result wins over a same-cycle handshake
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      digits_out   <= '0;
      overflow_out <= 1'b0;
      valid_out    <= 1'b0;
      overrun_out  <= 1'b0;
    end else if (w_gate_end) begin
      digits_out   <= w_bcd_next;
      overflow_out <= w_ovf_next;
      valid_out    <= 1'b1;
      overrun_out  <= valid_out & ~ready_in;
    end else if (w_handshake) begin
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gated_freq_meter.sv
// Scoreboard bench for gated_freq_meter: a 3-digit/100-cycle instance exercised through
// rate, overrun, enable and reset scenarios, plus a 2-digit/400-cycle instance for saturation.
module tb_gated_freq_meter;

  logic        clk = 1'b0;
  logic        resetn, enable, ready, ready2;
  logic        sig1, sig2;
  logic [11:0] digits1;
  logic        ovf1, val1, ovr1;
  logic [7:0]  digits2;
  logic        ovf2, val2, ovr2;

  typedef struct {
    logic        care;
    logic [11:0] digits;
    logic        ovf;
    logic        ovr;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   per1, per2, ph1, ph2;

  always #5 clk = ~clk;

  gated_freq_meter #(.DIGITS_NUM(3), .GATE_CYCLES(100), .SYNC_STAGES(2)) u_dut1 (
    .clk_in(clk), .resetn_in(resetn), .sig_in(sig1), .enable_in(enable),
    .digits_out(digits1), .overflow_out(ovf1), .valid_out(val1),
    .ready_in(ready), .overrun_out(ovr1)
  );

  gated_freq_meter #(.DIGITS_NUM(2), .GATE_CYCLES(400), .SYNC_STAGES(2)) u_dut2 (
    .clk_in(clk), .resetn_in(resetn), .sig_in(sig2), .enable_in(1'b1),
    .digits_out(digits2), .overflow_out(ovf2), .valid_out(val2),
    .ready_in(ready2), .overrun_out(ovr2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push1(input logic care, input logic [11:0] d, input logic o, input logic r);
    exp_t e;
    e.care = care; e.digits = d; e.ovf = o; e.ovr = r;
    q1.push_back(e);
  endtask

  task automatic push2(input logic [11:0] d, input logic o);
    exp_t e;
    e.care = 1'b1; e.digits = d; e.ovf = o; e.ovr = 1'b0;
    q2.push_back(e);
  endtask

  // Counts clock edges until val1 is seen high, sampled just after each edge
  task automatic wait_valid(output int n, input int limit);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!val1 && n < limit);
  endtask

  task automatic drain1(input int limit);
    int k;
    k = 0;
    while (q1.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain1", 32'(q1.size()), 32'd0);
  endtask

  // Stimulus waveforms: low half first, phase restarted by reset or by a period change
  always @(posedge clk) begin
    #2;
    if (!resetn || per1 == 0) begin
      sig1 = 1'b0; ph1 = 0;
    end else begin
      sig1 = (ph1 >= per1 / 2);
      ph1  = (ph1 + 1 >= per1) ? 0 : ph1 + 1;
    end
    if (!resetn || per2 == 0) begin
      sig2 = 1'b0; ph2 = 0;
    end else begin
      sig2 = (ph2 >= per2 / 2);
      ph2  = (ph2 + 1 >= per2) ? 0 : ph2 + 1;
    end
  end

  // Handshake monitors: a result is consumed in a cycle with valid and ready both high
  always @(negedge clk) begin
    exp_t e;
    if (resetn && val1 && ready) begin
      if (q1.size() == 0) begin
        check_eq("sb1_pending", 32'(q1.size()), 32'd1);
      end else begin
        e = q1.pop_front();
        if (e.care) begin
          check_eq("sb1_digits", 32'(digits1), 32'(e.digits));
          check_eq("sb1_overflow", 32'(ovf1), 32'(e.ovf));
          check_eq("sb1_overrun", 32'(ovr1), 32'(e.ovr));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (resetn && val2 && ready2 && q2.size() != 0) begin
      e = q2.pop_front();
      check_eq("sb2_digits", 32'(digits2), 32'(e.digits));
      check_eq("sb2_overflow", 32'(ovf2), 32'(e.ovf));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Second instance: max rate for 300 cycles then period 10, so window 2 is clean
  initial begin
    wait (resetn === 1'b1);
    repeat (300) @(posedge clk);
    #1;
    per2 = 10; ph2 = 0;
  end

  initial begin
    int n, cnt, k;
    resetn = 1'b0; enable = 1'b0; ready = 1'b0; ready2 = 1'b1;
    per1 = 10; per2 = 2; ph1 = 0; ph2 = 0; sig1 = 1'b0; sig2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_digits", 32'(digits1), 32'd0);
    check_eq("rst_overflow", 32'(ovf1), 32'd0);
    check_eq("rst_valid", 32'(val1), 32'd0);
    check_eq("rst_overrun", 32'(ovr1), 32'd0);
    check_eq("rst_digits2", 32'(digits2), 32'd0);

    enable = 1'b1; ready = 1'b1;
    repeat (3) push1(1'b1, 12'h010, 1'b0, 1'b0);
    push2(12'h099, 1'b1);
    push2(12'h040, 1'b0);
    resetn = 1'b1;
    wait_valid(n, 300);
    check_eq("first_valid_cycle", 32'(n + 1), 32'd101);
    wait_valid(n, 300);
    check_eq("valid_period", 32'(n), 32'd100);
    drain1(400);

    @(posedge clk); #1;
    per1 = 2; ph1 = 0;
    push1(1'b0, 12'h000, 1'b0, 1'b0);
    repeat (2) push1(1'b1, 12'h050, 1'b0, 1'b0);
    drain1(500);

    @(posedge clk); #1;
    per1 = 0;
    push1(1'b0, 12'h000, 1'b0, 1'b0);
    repeat (2) push1(1'b1, 12'h000, 1'b0, 1'b0);
    drain1(500);

    @(posedge clk); #1;
    per1 = 10; ph1 = 0;
    push1(1'b0, 12'h000, 1'b0, 1'b0);
    push1(1'b1, 12'h010, 1'b0, 1'b0);
    drain1(400);

    // Two gate-ends with nobody consuming
    @(posedge clk); #1;
    ready = 1'b0;
    push1(1'b1, 12'h010, 1'b0, 1'b1);
    wait_valid(n, 200);
    check_eq("ovr_first_gate", 32'(ovr1), 32'd0);
    k = 0;
    while (!ovr1 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("ovr_set", 32'(ovr1), 32'd1);
    check_eq("ovr_valid", 32'(val1), 32'd1);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    check_eq("ovr_clr_valid", 32'(val1), 32'd0);
    check_eq("ovr_clr_flag", 32'(ovr1), 32'd0);

    // Handshake landing on the gate-end edge
    push1(1'b1, 12'h010, 1'b0, 1'b0);
    push1(1'b1, 12'h010, 1'b0, 1'b0);
    wait_valid(n, 200);
    repeat (99) @(posedge clk);
    #1;
    ready = 1'b1;
    @(posedge clk); #1;
    check_eq("hs_gate_valid", 32'(val1), 32'd1);
    check_eq("hs_gate_overrun", 32'(ovr1), 32'd0);
    drain1(100);

    // Enable gap mid-window
    repeat (50) @(posedge clk);
    #1;
    enable = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (val1) cnt++;
    end
    check_eq("dis_no_valid", 32'(cnt), 32'd0);
    enable = 1'b1;
    push1(1'b1, 12'h010, 1'b0, 1'b0);
    wait_valid(n, 300);
    check_eq("reenable_result_edge", 32'(n), 32'd100);
    drain1(50);

    k = 0;
    while (q2.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain2", 32'(q2.size()), 32'd0);

    // Reset mid-window
    repeat (40) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check_eq("arst_digits", 32'(digits1), 32'd0);
    check_eq("arst_overflow", 32'(ovf1), 32'd0);
    check_eq("arst_valid", 32'(val1), 32'd0);
    check_eq("arst_overrun", 32'(ovr1), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    push1(1'b1, 12'h010, 1'b0, 1'b0);
    wait_valid(n, 300);
    check_eq("rst_first_valid_cycle", 32'(n + 1), 32'd101);
    drain1(50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
